piano_voice_allocator: RTL and testbench



---
 rtl/piano_voice_allocator.sv | 138 +++++++++++++
 tb/tb_piano_voice_allocator.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/piano_voice_allocator.sv
// piano_voice_allocator
//   Assigns decoded key events to a fixed pool of tone-generator voices.
//   A press goes to the lowest-index free voice. When every voice is busy, the
//   least-recently-allocated voice is stolen. A release frees the voice that
//   holds the released scancode.
//
// Ports
//   clk_100mhz    system clock
//   rst_n         asynchronous reset, active low
//   evt_valid     single-cycle strobe: a key event is present
//   evt_press     1 = press (make), 0 = release (break)
//   evt_code      scancode of the event
//   all_off       panic input: release every voice (overrides evt_valid)
//   voice_active  per-voice gate (registered)
//   voice_code    scancode of voice i at bits [8i+7:8i] (registered)
//   voice_start   one-cycle pulse: voice i was (re)triggered with a new code
//   steal         one-cycle pulse: the last allocation evicted an active voice
//   active_count  number of active voices
module piano_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int RANK_W     = 2
) (
  input  logic                    clk_100mhz,
  input  logic                    rst_n,
  input  logic                    evt_valid,
  input  logic                    evt_press,
  input  logic [7:0]              evt_code,
  input  logic                    all_off,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [8*NUM_VOICES-1:0] voice_code,
  output logic [NUM_VOICES-1:0]   voice_start,
  output logic                    steal,
  output logic [3:0]              active_count
);

  // Age rank per voice: 0 = newest, NUM_VOICES-1 = oldest. Always a permutation.
  logic [RANK_W-1:0] rank_q    [NUM_VOICES];
  logic [RANK_W-1:0] rank_d    [NUM_VOICES];
  logic [7:0]        code_q    [NUM_VOICES];
  logic [7:0]        code_d    [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_d;
  logic [NUM_VOICES-1:0] start_d;
  logic                  steal_d;
  logic [3:0]            count_d;

  logic              match;
  logic [RANK_W-1:0] match_idx;
  logic              free_found;
  logic [RANK_W-1:0] free_idx;
  logic [RANK_W-1:0] old_idx;
  logic [RANK_W-1:0] alloc_idx;

  // Lookup: active voice holding evt_code, lowest free voice, oldest voice.
  always_comb begin
    match      = 1'b0;
    match_idx  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_active[i] && (code_q[i] == evt_code)) begin
        match     = 1'b1;
        match_idx = RANK_W'(i);
      end
      if (!voice_active[i]) begin
        free_found = 1'b1;
        free_idx   = RANK_W'(i);
      end
      if (rank_q[i] == RANK_W'(NUM_VOICES - 1)) begin
        old_idx = RANK_W'(i);
      end
    end
    alloc_idx = free_found ? free_idx : old_idx;
  end

  always_comb begin
    active_d = voice_active;
    code_d   = code_q;
    rank_d   = rank_q;
    start_d  = '0;
    steal_d  = 1'b0;
    if (all_off) begin
      active_d = '0;
    end else if (evt_valid) begin
      if (evt_press) begin
        // Code 0 and typematic repeats of a held key are dropped.
        if ((evt_code != 8'h00) && !match) begin
          active_d[alloc_idx] = 1'b1;
          code_d[alloc_idx]   = evt_code;
          start_d[alloc_idx]  = 1'b1;
          steal_d             = !free_found;
          for (int j = 0; j < NUM_VOICES; j++) begin
            if (rank_q[j] < rank_q[alloc_idx]) begin
              rank_d[j] = rank_q[j] + 1'b1;
            end
          end
          rank_d[alloc_idx] = '0;
        end
      end else if (match) begin
        active_d[match_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      count_d = count_d + {3'b000, active_d[i]};
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      voice_active <= '0;
      voice_start  <= '0;
      steal        <= 1'b0;
      active_count <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        code_q[i] <= '0;
        rank_q[i] <= RANK_W'(i);
      end
    end else begin
      voice_active <= active_d;
      voice_start  <= start_d;
      steal        <= steal_d;
      active_count <= count_d;
      code_q       <= code_d;
      rank_q       <= rank_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_code[8*i +: 8] = code_q[i];
    end
  end

endmodule

// File: tb/tb_piano_voice_allocator.sv
module tb_piano_voice_allocator;

  logic        clk_100mhz = 1'b0;
  logic        rst_n;
  logic        evt_valid;
  logic        evt_press;
  logic [7:0]  evt_code;
  logic        all_off;
  logic [3:0]  voice_active;
  logic [31:0] voice_code;
  logic [3:0]  voice_start;
  logic        steal;
  logic [3:0]  active_count;

  int checks = 0;
  int errors = 0;

  piano_voice_allocator #(.NUM_VOICES(4), .RANK_W(2)) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .evt_valid   (evt_valid),
    .evt_press   (evt_press),
    .evt_code    (evt_code),
    .all_off     (all_off),
    .voice_active(voice_active),
    .voice_code  (voice_code),
    .voice_start (voice_start),
    .steal       (steal),
    .active_count(active_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    string       name;
    logic        valid;
    logic        press;
    logic [7:0]  code;
    logic        off;
    logic [3:0]  exp_active;
    logic [31:0] exp_code;
    logic [3:0]  exp_start;
    logic        exp_steal;
    logic [3:0]  exp_count;
  } vec_t;

  vec_t vecs[$];
  vec_t vecs2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input vec_t v);
    check({v.name, " active"}, 32'(voice_active), 32'(v.exp_active));
    check({v.name, " code"},   voice_code,        v.exp_code);
    check({v.name, " start"},  32'(voice_start),  32'(v.exp_start));
    check({v.name, " steal"},  32'(steal),        32'(v.exp_steal));
    check({v.name, " count"},  32'(active_count), 32'(v.exp_count));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk_100mhz);
    evt_valid = v.valid;
    evt_press = v.press;
    evt_code  = v.code;
    all_off   = v.off;
    @(posedge clk_100mhz);
    #1;
    check_all(v);
  endtask

  function automatic vec_t mk(input string n, input logic va, input logic pr, input logic [7:0] c,
                              input logic off, input logic [3:0] ea, input logic [31:0] ec,
                              input logic [3:0] es, input logic est, input logic [3:0] en);
    vec_t v;
    v.name = n; v.valid = va; v.press = pr; v.code = c; v.off = off;
    v.exp_active = ea; v.exp_code = ec; v.exp_start = es; v.exp_steal = est; v.exp_count = en;
    return v;
  endfunction

  initial begin
    vec_t z;
    //               name         vld pr code   off  active    code           start  stl cnt
    vecs.push_back(mk("p1C",       1, 1, 8'h1C, 0, 4'b0001, 32'h0000001C, 4'b0001, 0, 4'd1));
    vecs.push_back(mk("rep1C",     1, 1, 8'h1C, 0, 4'b0001, 32'h0000001C, 4'b0000, 0, 4'd1));
    vecs.push_back(mk("off1",      0, 0, 8'h00, 1, 4'b0000, 32'h0000001C, 4'b0000, 0, 4'd0));
    vecs.push_back(mk("f1C",       1, 1, 8'h1C, 0, 4'b0001, 32'h0000001C, 4'b0001, 0, 4'd1));
    vecs.push_back(mk("f1B",       1, 1, 8'h1B, 0, 4'b0011, 32'h00001B1C, 4'b0010, 0, 4'd2));
    vecs.push_back(mk("f23",       1, 1, 8'h23, 0, 4'b0111, 32'h00231B1C, 4'b0100, 0, 4'd3));
    vecs.push_back(mk("f2B",       1, 1, 8'h2B, 0, 4'b1111, 32'h2B231B1C, 4'b1000, 0, 4'd4));
    vecs.push_back(mk("steal34",   1, 1, 8'h34, 0, 4'b1111, 32'h2B231B34, 4'b0001, 1, 4'd4));
    vecs.push_back(mk("rel1C",     1, 0, 8'h1C, 0, 4'b1111, 32'h2B231B34, 4'b0000, 0, 4'd4));
    vecs.push_back(mk("rel23",     1, 0, 8'h23, 0, 4'b1011, 32'h2B231B34, 4'b0000, 0, 4'd3));
    vecs.push_back(mk("p3B",       1, 1, 8'h3B, 0, 4'b1111, 32'h2B3B1B34, 4'b0100, 0, 4'd4));
    vecs.push_back(mk("rep1B",     1, 1, 8'h1B, 0, 4'b1111, 32'h2B3B1B34, 4'b0000, 0, 4'd4));
    vecs.push_back(mk("p00",       1, 1, 8'h00, 0, 4'b1111, 32'h2B3B1B34, 4'b0000, 0, 4'd4));
    vecs.push_back(mk("steal44",   1, 1, 8'h44, 0, 4'b1111, 32'h2B3B4434, 4'b0010, 1, 4'd4));
    vecs.push_back(mk("idle",      0, 0, 8'h00, 0, 4'b1111, 32'h2B3B4434, 4'b0000, 0, 4'd4));
    vecs.push_back(mk("steal55",   1, 1, 8'h55, 0, 4'b1111, 32'h553B4434, 4'b1000, 1, 4'd4));
    vecs.push_back(mk("offp4B",    1, 1, 8'h4B, 1, 4'b0000, 32'h553B4434, 4'b0000, 0, 4'd0));
    vecs.push_back(mk("p4B",       1, 1, 8'h4B, 0, 4'b0001, 32'h553B444B, 4'b0001, 0, 4'd1));
    vecs.push_back(mk("rel4B",     1, 0, 8'h4B, 0, 4'b0000, 32'h553B444B, 4'b0000, 0, 4'd0));
    vecs.push_back(mk("rel4B2",    1, 0, 8'h4B, 0, 4'b0000, 32'h553B444B, 4'b0000, 0, 4'd0));
    vecs.push_back(mk("pre_rst",   1, 1, 8'h1C, 0, 4'b0001, 32'h553B441C, 4'b0001, 0, 4'd1));

    // After the mid-cycle reset: ranks are back to identity, so the fifth
    // press must steal voice 0.
    vecs2.push_back(mk("r_p1C",    1, 1, 8'h1C, 0, 4'b0001, 32'h0000001C, 4'b0001, 0, 4'd1));
    vecs2.push_back(mk("r_p1B",    1, 1, 8'h1B, 0, 4'b0011, 32'h00001B1C, 4'b0010, 0, 4'd2));
    vecs2.push_back(mk("r_p23",    1, 1, 8'h23, 0, 4'b0111, 32'h00231B1C, 4'b0100, 0, 4'd3));
    vecs2.push_back(mk("r_p2B",    1, 1, 8'h2B, 0, 4'b1111, 32'h2B231B1C, 4'b1000, 0, 4'd4));
    vecs2.push_back(mk("r_st34",   1, 1, 8'h34, 0, 4'b1111, 32'h2B231B34, 4'b0001, 1, 4'd4));
    vecs2.push_back(mk("r_idle",   0, 0, 8'h00, 0, 4'b1111, 32'h2B231B34, 4'b0000, 0, 4'd4));

    z = mk("rst", 0, 0, 8'h00, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'd0);

    rst_n = 1'b0; evt_valid = 1'b0; evt_press = 1'b0; evt_code = 8'h00; all_off = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    check_all(z);
    @(negedge clk_100mhz);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset asserted in the middle of the cycle in which voice_start pulses.
    evt_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    z.name = "midrst";
    check_all(z);
    @(negedge clk_100mhz);
    rst_n = 1'b1;

    foreach (vecs2[i]) apply(vecs2[i]);

    @(negedge clk_100mhz);
    evt_valid = 1'b0;
    all_off   = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
